rv32_alu: RTL and testbench

- Integer ALU for the KISC-V RV32I microcoded core.
- Computes the RV32I register and immediate arithmetic, logic, shift and set-less-than results from a 4-bit op code and two operands.
- Also computes a branch-compare flag selected by the funct3 field.
- Outputs are registered: one pipeline stage between the operand/op inputs and the result/flag outputs. The core's microcode budgets one cycle for this.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_shifter.sv | 38 +++
 rtl/rv32_alu.sv | 122 ++++++++++++
 tb/tb_rv32_alu.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the KISC-V RV32I integer ALU.
//   ALU_*  : 4-bit ALU op codes {funct7[5], funct3}. For ops where bit 3 is
//            don't-care, the constant carries bit 3 = 0.
//   BR_*   : branch funct3 codes that select the compare flag.
//   SH_*   : barrel-shifter mode encodings.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [2:0] BR_EQ    = 3'b000;
    localparam logic [2:0] BR_NE    = 3'b001;
    localparam logic [2:0] BR_SLT   = 3'b010;
    localparam logic [2:0] BR_SLTU  = 3'b011;
    localparam logic [2:0] BR_LT    = 3'b100;
    localparam logic [2:0] BR_GE    = 3'b101;
    localparam logic [2:0] BR_LTU   = 3'b110;
    localparam logic [2:0] BR_GEU   = 3'b111;

    localparam logic [1:0] SH_LEFT  = 2'b00;
    localparam logic [1:0] SH_SRL   = 2'b01;
    localparam logic [1:0] SH_SRA   = 2'b10;

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
// Combinational barrel shifter for the RV32I ALU.
// Ports:
//   a     in  DATA_WIDTH  value to shift
//   shamt in  SHAMT_W     shift distance
//   mode  in  2           SH_LEFT / SH_SRL / SH_SRA
//   y     out DATA_WIDTH  shifted value
// ---------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] sra_s;

    // Sign-filling right shift via the signed shift operator.
    assign sra_s = DATA_WIDTH'($signed(a) >>> shamt);

    // Select the shift direction; the unused encoding yields zero.
    always_comb begin
        y = {DATA_WIDTH{1'b0}};
        case (mode)
            SH_LEFT: y = a << shamt;
            SH_SRL:  y = a >> shamt;
            SH_SRA:  y = sra_s;
            default: y = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/rv32_alu.sv
// ---------------------------------------------------------------------------
// rv32_alu
// Registered integer ALU for the KISC-V RV32I microcoded core. Computes the
// arithmetic/logic/shift/set-less-than result selected by alu_op and a
// branch-compare flag selected by alu_op[2:0]; both are registered, so the
// outputs reflect the inputs sampled at the previous rising edge.
// Ports:
//   APB_PCLK    in   1           clock, rising edge
//   APB_PRESETn in   1           asynchronous active-low reset
//   alu_op      in   4           {funct7[5], funct3}
//   a           in   DATA_WIDTH  operand A (rs1)
//   b           in   DATA_WIDTH  operand B (rs2 or immediate)
//   result      out  DATA_WIDTH  registered ALU result
//   cmp_flag    out  1           registered branch-compare outcome
// ---------------------------------------------------------------------------
module rv32_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  APB_PCLK,
    input  logic                  APB_PRESETn,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cmp_flag
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic [2:0]            funct3_s;
    logic                  eq_s;
    logic                  lt_s;
    logic                  ltu_s;
    logic [1:0]            sh_mode_s;
    logic [DATA_WIDTH-1:0] sh_out_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  cmp_s;
    logic [DATA_WIDTH-1:0] result_r;
    logic                  cmp_r;

    assign funct3_s = alu_op[2:0];
    assign eq_s     = (a == b);
    assign lt_s     = ($signed(a) < $signed(b));
    assign ltu_s    = (a < b);

    // Shift direction: funct3 001 is always left; otherwise bit 3 picks SRA.
    always_comb begin
        sh_mode_s = SH_SRL;
        if (funct3_s == ALU_SLL[2:0]) begin
            sh_mode_s = SH_LEFT;
        end else if (alu_op[3]) begin
            sh_mode_s = SH_SRA;
        end else begin
            sh_mode_s = SH_SRL;
        end
    end

    alu_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_shifter (
        .a     (a),
        .shamt (b[SHAMT_W-1:0]),
        .mode  (sh_mode_s),
        .y     (sh_out_s)
    );

    // Result mux; bit 3 only distinguishes ADD/SUB and SRL/SRA.
    always_comb begin
        result_s = {DATA_WIDTH{1'b0}};
        case (funct3_s)
            ALU_ADD[2:0]: begin
                if (alu_op[3]) begin
                    result_s = a - b;
                end else begin
                    result_s = a + b;
                end
            end
            ALU_SLL[2:0]:  result_s = sh_out_s;
            ALU_SLT[2:0]:  result_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU[2:0]: result_s = {{(DATA_WIDTH-1){1'b0}}, ltu_s};
            ALU_XOR[2:0]:  result_s = a ^ b;
            ALU_SRL[2:0]:  result_s = sh_out_s;
            ALU_OR[2:0]:   result_s = a | b;
            ALU_AND[2:0]:  result_s = a & b;
            default:       result_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Branch-compare flag, produced for every op; the core qualifies it.
    always_comb begin
        cmp_s = 1'b0;
        case (funct3_s)
            BR_EQ:   cmp_s = eq_s;
            BR_NE:   cmp_s = ~eq_s;
            BR_SLT:  cmp_s = lt_s;
            BR_SLTU: cmp_s = ltu_s;
            BR_LT:   cmp_s = lt_s;
            BR_GE:   cmp_s = ~lt_s;
            BR_LTU:  cmp_s = ltu_s;
            BR_GEU:  cmp_s = ~ltu_s;
            default: cmp_s = 1'b0;
        endcase
    end

    // Output pipeline register, cleared asynchronously by reset.
    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            result_r <= {DATA_WIDTH{1'b0}};
            cmp_r    <= 1'b0;
        end else begin
            result_r <= result_s;
            cmp_r    <= cmp_s;
        end
    end

    assign result   = result_r;
    assign cmp_flag = cmp_r;

endmodule

// File: tb/tb_rv32_alu.sv
// ---------------------------------------------------------------------------
// tb_rv32_alu
// Directed-vector bench for rv32_alu with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_rv32_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        cmp_flag;

    int tests_run    = 0;
    int tests_failed = 0;

    rv32_alu #(.DATA_WIDTH(32)) dut (
        .APB_PCLK    (clk),
        .APB_PRESETn (rst_n),
        .alu_op      (alu_op),
        .a           (a),
        .b           (b),
        .result      (result),
        .cmp_flag    (cmp_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, check both outputs just after the
    // next rising edge. Consecutive calls present back-to-back ops.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_res, input logic exp_flag);
        @(negedge clk);
        alu_op = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        check_val({tag, ".res"}, result, exp_res);
        check_val({tag, ".flag"}, {31'd0, cmp_flag}, {31'd0, exp_flag});
    endtask

    initial begin
        rst_n  = 1'b0;
        alu_op = 4'b0000;
        a      = 32'd5;
        b      = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.res", result, 32'd0);
        check_val("rst.flag", {31'd0, cmp_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel.res", result, 32'h0000_000C);
        check_val("rel.flag", {31'd0, cmp_flag}, 32'd0);

        // Arithmetic
        do_op("sub0m1",  4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        do_op("add01",   4'b0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
        do_op("addwrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        // Shifts
        do_op("sra31",   4'b1101, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0);
        do_op("srl31",   4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0);
        do_op("sll4",    4'b0001, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 1'b1);
        do_op("srapos",  4'b1101, 32'h4000_0000, 32'h0000_001E, 32'h0000_0001, 1'b1);
        do_op("srl0",    4'b0101, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
        // Compares with a=-1, b=1
        do_op("slt",     4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1);
        do_op("sltu",    4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
        do_op("blt",     4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
        do_op("bltu",    4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        do_op("bgeu",    4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1);
        // Equality
        do_op("beq",     4'b0000, 32'h0000_1234, 32'h0000_1234, 32'h0000_2468, 1'b1);
        do_op("bne",     4'b0001, 32'h0000_1234, 32'h0000_1234, 32'h2340_0000, 1'b0);
        do_op("bge",     4'b0101, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1);
        // Bit 3 ignored outside ADD/SUB and SRL/SRA; most-negative boundary
        do_op("slt_b3",  4'b1010, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b1);
        do_op("sltu_b3", 4'b1011, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        do_op("xor_b3",  4'b1100, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b1);
        do_op("or_b3",   4'b1110, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0);
        do_op("and_b3",  4'b1111, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b1);
        do_op("minneg",  4'b0100, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        // Back-to-back pipeline
        do_op("pipe0",   4'b0000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0);
        do_op("pipe1",   4'b0100, 32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b1);
        do_op("pipe2",   4'b0111, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b1);

        // Reset asserted mid-stream, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst.res", result, 32'd0);
        check_val("midrst.flag", {31'd0, cmp_flag}, 32'd0);
        @(negedge clk);
        alu_op = 4'b0000;
        a      = 32'd2;
        b      = 32'd2;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check_val("afterrst.res", result, 32'd4);
        check_val("afterrst.flag", {31'd0, cmp_flag}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
